keypad_sync_debounce: RTL and testbench

Multi-channel input conditioner for asynchronous keypad and switch inputs. Each channel passes through a parametrised-depth synchronizer chain, then a per-channel debounce counter, then an edge detector. The block sits between the FPGA input pins and the keypad scan FSM. It provides a clean level, single-cycle rise/fall pulses, and an any-change strobe per channel.

---
 rtl/keypad_sync_debounce.sv | 104 ++++++++++
 tb/tb_keypad_sync_debounce.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_sync_debounce.sv
// Keypad/switch input conditioner: per-channel sync chain, debounce
// counter and registered rise/fall/any-change pulse generation.
//
// Ports:
//   clk        system clock
//   nrst       synchronous active-low reset
//   sample_en  debounce sample strobe (counters advance only when high)
//   data_d     raw asynchronous inputs, WIDTH bits
//   data_sync  last synchronizer stage (not debounced)
//   data_q     debounced level
//   rise       1-cycle pulse when data_q[i] goes 0->1
//   fall       1-cycle pulse when data_q[i] goes 1->0
//   any_change OR of all rise/fall bits, registered with them
module keypad_sync_debounce #(
  parameter int              WIDTH     = 4,
  parameter int              STAGES    = 2,
  parameter int              DB_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] data_d,
  output logic [WIDTH-1:0] data_sync,
  output logic [WIDTH-1:0] data_q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_change
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [CW-1:0]    cnt_q  [WIDTH];
  logic [CW-1:0]    cnt_d  [WIDTH];
  logic [WIDTH-1:0] lvl_q, lvl_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             chg_q, chg_d;
  logic [WIDTH-1:0] acc;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int s = 0; s < STAGES; s++)
        sync_q[s] <= RESET_VAL;
    end else begin
      sync_q[0] <= data_d;
      for (int s = 1; s < STAGES; s++)
        sync_q[s] <= sync_q[s-1];
    end
  end

  assign data_sync = sync_q[STAGES-1];

  // A channel accepts the synced level once it has disagreed with
  // the debounced level for DB_CYCLES sample strobes in a row; any
  // agreeing edge (strobed or not) restarts the count.
  always_comb begin
    lvl_d = lvl_q;
    acc   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (data_sync[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (sample_en) begin
        if (cnt_q[i] == CMAX) begin
          acc[i]   = 1'b1;
          lvl_d[i] = data_sync[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    rise_d = acc & data_sync;
    fall_d = acc & ~data_sync;
    chg_d  = |acc;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      lvl_q  <= RESET_VAL;
      rise_q <= '0;
      fall_q <= '0;
      chg_q  <= 1'b0;
      for (int i = 0; i < WIDTH; i++)
        cnt_q[i] <= '0;
    end else begin
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      chg_q  <= chg_d;
      for (int i = 0; i < WIDTH; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

  assign data_q     = lvl_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign any_change = chg_q;

endmodule

// File: tb/tb_keypad_sync_debounce.sv
// Bench for keypad_sync_debounce: default instance plus a
// STAGES=3/DB_CYCLES=1 instance, both checked against a cycle model.
module tb_keypad_sync_debounce;

  logic       clk = 1'b0;
  logic       nrst;
  logic       se;
  logic [3:0] dd;

  logic [3:0] ds1, q1, r1, f1;
  logic       a1;
  logic [3:0] ds2, q2, r2, f2;
  logic       a2;

  int ntot = 0;
  int npass = 0;

  always #5 clk = ~clk;

  keypad_sync_debounce u1 (
    .clk(clk), .nrst(nrst), .sample_en(se), .data_d(dd),
    .data_sync(ds1), .data_q(q1), .rise(r1), .fall(f1),
    .any_change(a1)
  );

  keypad_sync_debounce #(.STAGES(3), .DB_CYCLES(1)) u2 (
    .clk(clk), .nrst(nrst), .sample_en(se), .data_d(dd),
    .data_sync(ds2), .data_q(q2), .rise(r2), .fall(f2),
    .any_change(a2)
  );

  // reference model: delay line of raw samples, and per channel the
  // number of strobed samples the synced level has spent disagreeing
  logic [3:0] msync [2][4];
  logic [3:0] mq [2];
  logic [3:0] mr [2];
  logic [3:0] mf [2];
  logic       ma [2];
  int         pend [2][4];

  task automatic mstep(int k, int st, int db);
    logic [3:0] s;
    s = msync[k][st-1];
    mr[k] = '0;
    mf[k] = '0;
    if (!nrst) begin
      for (int j = 0; j < 4; j++) msync[k][j] = '0;
      for (int i = 0; i < 4; i++) pend[k][i] = 0;
      mq[k] = '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (s[i] == mq[k][i]) pend[k][i] = 0;
        else if (se) begin
          pend[k][i] = pend[k][i] + 1;
          if (pend[k][i] >= db) begin
            mq[k][i] = s[i];
            pend[k][i] = 0;
            if (s[i]) mr[k][i] = 1'b1;
            else mf[k][i] = 1'b1;
          end
        end
      end
      for (int j = st - 1; j > 0; j--) msync[k][j] = msync[k][j-1];
      msync[k][0] = dd;
    end
    ma[k] = |(mr[k] | mf[k]);
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    mstep(0, 2, 4);
    mstep(1, 3, 1);
    #1;
    chk("u1.data_sync", 32'(ds1), 32'(msync[0][1]));
    chk("u1.data_q", 32'(q1), 32'(mq[0]));
    chk("u1.rise", 32'(r1), 32'(mr[0]));
    chk("u1.fall", 32'(f1), 32'(mf[0]));
    chk("u1.any_change", 32'(a1), 32'(ma[0]));
    chk("u2.data_sync", 32'(ds2), 32'(msync[1][2]));
    chk("u2.data_q", 32'(q2), 32'(mq[1]));
    chk("u2.rise", 32'(r2), 32'(mr[1]));
    chk("u2.fall", 32'(f2), 32'(mf[1]));
    chk("u2.any_change", 32'(a2), 32'(ma[1]));
  endtask

  initial begin
    int sen;
    int npulse;
    logic pre;

    // reset
    nrst = 1'b0; se = 1'b1; dd = 4'b0000;
    repeat (3) tick();
    chk("rst.data_q", 32'(q1), 32'h0);
    chk("rst.any_change", 32'(a1), 32'h0);
    nrst = 1'b1;
    repeat (3) tick();

    // clean step, both parameter sets
    dd = 4'b0001;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (e == 1) chk("step.sync_e1", 32'(ds1[0]), 32'h1);
      if (e == 4) chk("step.q_e4", 32'(q1), 32'h0);
      if (e == 5) begin
        chk("step.q_e5", 32'(q1), 32'h1);
        chk("step.rise_e5", 32'(r1), 32'h1);
        chk("step.any_e5", 32'(a1), 32'h1);
      end
      if (e == 6) chk("step.rise_e6", 32'(r1), 32'h0);
      chk("step.fall", 32'(f1), 32'h0);
      if (e == 2) chk("sweep.q_e2", 32'(q2), 32'h0);
      if (e == 3) begin
        chk("sweep.q_e3", 32'(q2), 32'h1);
        chk("sweep.rise_e3", 32'(r2), 32'h1);
      end
      if (e == 4) chk("sweep.rise_e4", 32'(r2), 32'h0);
    end

    // glitch on channel 1, three cycles wide
    dd = 4'b0011;
    repeat (3) tick();
    dd = 4'b0001;
    for (int e = 0; e < 8; e++) begin
      tick();
      chk("glitch.q", 32'(q1), 32'h1);
      chk("glitch.rise", 32'(r1), 32'h0);
      chk("glitch.any", 32'(a1), 32'h0);
    end

    // gated sampling: strobe every 4th cycle, channel 2 steps up
    dd = 4'b0101;
    sen = 0;
    for (int c = 0; c < 40; c++) begin
      se = (c % 4 == 3);
      pre = ds1[2];
      tick();
      if (pre && se) sen++;
      chk("gate.q2", 32'(q1[2]), 32'(sen >= 4));
    end
    se = 1'b1;

    // simultaneous channels
    dd = 4'b0011;
    repeat (10) tick();
    dd = 4'b1100;
    npulse = 0;
    for (int e = 0; e < 9; e++) begin
      tick();
      if (a1) npulse++;
      if (e == 4) chk("simul.q_e4", 32'(q1), 32'h3);
      if (e == 5) begin
        chk("simul.q", 32'(q1), 32'hc);
        chk("simul.rise", 32'(r1), 32'hc);
        chk("simul.fall", 32'(f1), 32'h3);
      end
    end
    chk("simul.npulse", 32'(npulse), 32'h1);

    // reset mid-count on channel 3
    dd = 4'b0100;
    tick();
    tick();
    nrst = 1'b0;
    tick();
    chk("rmid.q", 32'(q1), 32'h0);
    chk("rmid.fall", 32'(f1), 32'h0);
    chk("rmid.any", 32'(a1), 32'h0);
    chk("rmid.sync", 32'(ds1), 32'h0);
    nrst = 1'b1;
    npulse = 0;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (e == 4) chk("rmid.q_e4", 32'(q1), 32'h0);
      if (e == 5) chk("rmid.q_e5", 32'(q1), 32'h4);
    end

    // randomized run against the model
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 5) == 0) dd[i] = ~dd[i];
      se = ($urandom_range(0, 3) != 0);
      nrst = ($urandom_range(0, 99) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
